// File: rtl/dino_jump_ctrl.sv
// dino_jump_ctrl
//   Jump controller for a side-scrolling dino game. The raw push-button is
//   synchronised and debounced, and each clean press launches the dino. Its
//   height then follows a simple gravity model that advances once per
//   physics tick.
//
//   Optional feature macro: DOUBLE_JUMP_EN. When it is defined, the dino may
//   re-launch once while airborne. The flag that allows this is cleared when
//   the dino lands, when game_run is low, and on reset.
//
// Parameters
//   DEBOUNCE_CYCLES  identical synchronised samples needed to accept a new level
//   TICK_CYCLES      clk cycles per physics tick
//   V0               launch velocity, px/tick (1..63)
//   GRAVITY          velocity change per tick, px/tick (1..V0)
//
// Ports
//   clk         system clock; all logic uses the rising edge
//   clr         asynchronous active-low reset
//   jump_btn    raw, bouncing jump button (1 = pressed)
//   game_run    1 = game active; 0 = hold the dino on the ground
//   height      registered height above ground, in px
//   airborne    registered; 1 while ascending or descending
//   jump_start  one-cycle pulse on each launch
//   landed      one-cycle pulse on touchdown
module dino_jump_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned TICK_CYCLES     = 833333,
  parameter int unsigned V0              = 12,
  parameter int unsigned GRAVITY         = 1
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       jump_btn,
  input  logic       game_run,
  output logic [7:0] height,
  output logic       airborne,
  output logic       jump_start,
  output logic       landed
);

  localparam int unsigned DBW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned TKW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [DBW-1:0] DB_LAST = DBW'(DEBOUNCE_CYCLES - 1);
  localparam logic [TKW-1:0] TK_LAST = TKW'(TICK_CYCLES - 1);
  localparam logic [5:0]     V0_L    = 6'(V0);
  localparam logic [5:0]     G_L     = 6'(GRAVITY);

  typedef enum logic [1:0] {
    GROUND  = 2'd0,
    ASCEND  = 2'd1,
    DESCEND = 2'd2
  } state_e;

  // Button synchroniser and debouncer
  logic           sync1_q, sync2_q;
  logic           deb_q, deb_d, deb_prev_q;
  logic [DBW-1:0] dcnt_q, dcnt_d;
  logic           press;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      deb_q      <= 1'b0;
      deb_prev_q <= 1'b0;
      dcnt_q     <= '0;
    end else begin
      sync1_q    <= jump_btn;
      sync2_q    <= sync1_q;
      deb_q      <= deb_d;
      deb_prev_q <= deb_q;
      dcnt_q     <= dcnt_d;
    end
  end

  // The counter runs only while the synchronised sample disagrees with the
  // accepted level. Any agreeing sample restarts the count.
  always_comb begin
    deb_d  = deb_q;
    dcnt_d = '0;
    if (sync2_q != deb_q) begin
      if (dcnt_q == DB_LAST) begin
        deb_d = sync2_q;
      end else begin
        dcnt_d = dcnt_q + DBW'(1);
      end
    end
  end

  assign press = deb_q & ~deb_prev_q;

  // Free-running physics tick
  logic [TKW-1:0] tcnt_q, tcnt_d;
  logic           tick;

  assign tick   = (tcnt_q == TK_LAST);
  assign tcnt_d = tick ? '0 : tcnt_q + TKW'(1);

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      tcnt_q <= '0;
    end else begin
      tcnt_q <= tcnt_d;
    end
  end

  // Jump FSM and physics
  state_e     state_q, state_d;
  logic [5:0] vel_q, vel_d;
  logic [7:0] height_q, height_d;
  logic       airborne_q, jump_start_q, js_d, landed_q, ld_d;
  logic [8:0] asc_sum;
  logic [6:0] dsc_sum;
  logic [5:0] dsc_vel;

  // Rising height saturates at 255; falling speed saturates at 63.
  assign asc_sum = {1'b0, height_q} + {3'b000, vel_q};
  assign dsc_sum = {1'b0, vel_q} + {1'b0, G_L};
  assign dsc_vel = dsc_sum[6] ? 6'd63 : dsc_sum[5:0];

`ifdef DOUBLE_JUMP_EN
  logic dbl_q, dbl_d;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      dbl_q <= 1'b0;
    end else begin
      dbl_q <= dbl_d;
    end
  end
`endif

  always_comb begin
    state_d  = state_q;
    vel_d    = vel_q;
    height_d = height_q;
    js_d     = 1'b0;
    ld_d     = 1'b0;
`ifdef DOUBLE_JUMP_EN
    dbl_d    = dbl_q;
`endif
    if (!game_run) begin
      state_d  = GROUND;
      vel_d    = '0;
      height_d = '0;
`ifdef DOUBLE_JUMP_EN
      dbl_d    = 1'b0;
`endif
    end else begin
      case (state_q)
        GROUND: begin
          if (press) begin
            state_d = ASCEND;
            vel_d   = V0_L;
            js_d    = 1'b1;
          end
        end
        ASCEND, DESCEND: begin
          // A launch (or re-launch) always wins over a coincident tick.
`ifdef DOUBLE_JUMP_EN
          if (press && !dbl_q) begin
            state_d = ASCEND;
            vel_d   = V0_L;
            js_d    = 1'b1;
            dbl_d   = 1'b1;
          end else
`endif
          if (tick) begin
            if (state_q == ASCEND) begin
              height_d = asc_sum[8] ? 8'hFF : asc_sum[7:0];
              if (vel_q <= G_L) begin
                vel_d   = '0;
                state_d = DESCEND;
              end else begin
                vel_d = vel_q - G_L;
              end
            end else begin
              if (height_q <= {2'b00, dsc_vel}) begin
                height_d = '0;
                vel_d    = '0;
                state_d  = GROUND;
                ld_d     = 1'b1;
`ifdef DOUBLE_JUMP_EN
                dbl_d    = 1'b0;
`endif
              end else begin
                height_d = height_q - {2'b00, dsc_vel};
                vel_d    = dsc_vel;
              end
            end
          end
        end
        default: begin
          state_d  = GROUND;
          vel_d    = '0;
          height_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q      <= GROUND;
      vel_q        <= '0;
      height_q     <= '0;
      airborne_q   <= 1'b0;
      jump_start_q <= 1'b0;
      landed_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      vel_q        <= vel_d;
      height_q     <= height_d;
      airborne_q   <= (state_d != GROUND);
      jump_start_q <= js_d;
      landed_q     <= ld_d;
    end
  end

  assign height     = height_q;
  assign airborne   = airborne_q;
  assign jump_start = jump_start_q;
  assign landed     = landed_q;

endmodule

// File: tb/tb_dino_jump_ctrl.sv
module tb_dino_jump_ctrl;
  localparam int DEB = 4;
  localparam int TCK = 2;
  localparam int V0  = 3;
  localparam int G   = 1;
`ifdef DOUBLE_JUMP_EN
  localparam bit DJ = 1'b1;
`else
  localparam bit DJ = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       clr = 1'b0;
  logic       jump_btn = 1'b0;
  logic       game_run = 1'b0;
  logic [7:0] height;
  logic       airborne, jump_start, landed;

  always #5 clk = ~clk;

  dino_jump_ctrl #(
    .DEBOUNCE_CYCLES(DEB),
    .TICK_CYCLES    (TCK),
    .V0             (V0),
    .GRAVITY        (G)
  ) dut (
    .clk       (clk),
    .clr       (clr),
    .jump_btn  (jump_btn),
    .game_run  (game_run),
    .height    (height),
    .airborne  (airborne),
    .jump_start(jump_start),
    .landed    (landed)
  );

  int checks = 0;
  int errors = 0;

  // Reference model, stepped from the rules in plain integer arithmetic.
  logic m_p1, m_p2, m_lvl, m_lvl_prev, m_dbl, m_js, m_ld;
  int   m_run, m_tcnt, m_mode, m_h, m_v;  // m_mode: 0 ground, 1 rising, 2 falling

  always @(posedge clk or negedge clr) begin : model
    int  h, v, mode, nv, run;
    bit  lvl, press, tick, dbl, js, ld;
    if (!clr) begin
      m_p1 <= 1'b0; m_p2 <= 1'b0; m_lvl <= 1'b0; m_lvl_prev <= 1'b0;
      m_run <= 0; m_tcnt <= 0; m_mode <= 0; m_h <= 0; m_v <= 0;
      m_dbl <= 1'b0; m_js <= 1'b0; m_ld <= 1'b0;
    end else begin
      lvl = m_lvl;
      run = m_run;
      if (m_p2 == m_lvl) run = 0;
      else begin
        run = run + 1;
        if (run >= DEB) begin lvl = m_p2; run = 0; end
      end
      press = m_lvl && !m_lvl_prev;
      tick  = (m_tcnt == TCK - 1);
      h = m_h; v = m_v; mode = m_mode; dbl = m_dbl; js = 1'b0; ld = 1'b0;
      if (!game_run) begin
        h = 0; v = 0; mode = 0; dbl = 1'b0;
      end else if (mode == 0) begin
        if (press) begin mode = 1; v = V0; js = 1'b1; end
      end else if (DJ && press && !dbl) begin
        mode = 1; v = V0; js = 1'b1; dbl = 1'b1;
      end else if (tick) begin
        if (mode == 1) begin
          h = (h + v > 255) ? 255 : h + v;
          if (v <= G) begin v = 0; mode = 2; end
          else v = v - G;
        end else begin
          nv = (v + G > 63) ? 63 : v + G;
          if (h <= nv) begin h = 0; v = 0; mode = 0; ld = 1'b1; dbl = 1'b0; end
          else begin h = h - nv; v = nv; end
        end
      end
      m_p1 <= jump_btn; m_p2 <= m_p1;
      m_lvl <= lvl; m_run <= run; m_lvl_prev <= m_lvl;
      m_tcnt <= tick ? 0 : m_tcnt + 1;
      m_h <= h; m_v <= v; m_mode <= mode; m_dbl <= dbl; m_js <= js; m_ld <= ld;
    end
  end

  // Per-cycle comparison against the model plus pulse-shape rules.
  bit   mon_en = 1'b0;
  logic prev_js = 1'b0, prev_ld = 1'b0;
  always @(negedge clk) begin
    logic [10:0] act, exp_v;
    if (mon_en) begin
      act   = {height, airborne, jump_start, landed};
      exp_v = {8'(m_h), (m_mode != 0), m_js, m_ld};
      checks++;
      if (act !== exp_v) begin
        errors++;
        $display("FAIL model_cmp t=%0t got h=%0d air=%b js=%b ld=%b, expected h=%0d air=%b js=%b ld=%b",
                 $time, act[10:3], act[2], act[1], act[0], exp_v[10:3], exp_v[2], exp_v[1], exp_v[0]);
      end
      checks++;
      if ((jump_start && landed) || (jump_start && prev_js) || (landed && prev_ld)) begin
        errors++;
        $display("FAIL pulse_rule t=%0t got js=%b ld=%b prev_js=%b prev_ld=%b, expected single isolated pulses",
                 $time, jump_start, landed, prev_js, prev_ld);
      end
    end
    prev_js = jump_start;
    prev_ld = landed;
  end

  // Observation recorder: height changes, launch heights, pulse counts.
  int   hq[$];
  int   jsq[$];
  int   jsidx[$];
  int   js_cnt = 0, ld_cnt = 0;
  logic [7:0] last_h = '0;
  always @(negedge clk) begin
    if (height !== last_h) begin
      hq.push_back(int'(height));
      last_h = height;
    end
    if (jump_start === 1'b1) begin
      js_cnt++;
      jsq.push_back(int'(height));
      jsidx.push_back(hq.size());
    end
    if (landed === 1'b1) ld_cnt++;
  end

  task automatic clear_rec();
    hq.delete(); jsq.delete(); jsidx.delete();
    js_cnt = 0; ld_cnt = 0; last_h = height;
  endtask

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_ground(input int budget);
    int n = 0;
    cyc(4);
    while ((airborne !== 1'b0 || height !== 8'd0) && n < budget) begin cyc(1); n++; end
    checks++;
    if (airborne !== 1'b0 || height !== 8'd0) begin
      errors++;
      $display("FAIL wait_ground timeout got h=%0d air=%b, expected h=0 air=0", height, airborne);
    end
  endtask

  task automatic align_tick(input int phase);
    int n = 0;
    while (m_tcnt != phase && n < 10) begin cyc(1); n++; end
  endtask

  task automatic test_reset();
    clr = 1'b0; game_run = 1'b0; jump_btn = 1'b1;
    mon_en = 1'b1;
    cyc(3);
    checks++;
    if ({height, airborne, jump_start, landed} !== 11'd0) begin
      errors++;
      $display("FAIL reset_state got h=%0d air=%b js=%b ld=%b, expected all 0", height, airborne, jump_start, landed);
    end
    game_run = 1'b1;
    clr = 1'b1;
    // Button already held: launch must still wait a full sync+debounce.
    for (int k = 1; k <= 7; k++) begin
      cyc(1);
      checks++;
      if (jump_start !== (k == 7)) begin
        errors++;
        $display("FAIL first_press_latency cycle=%0d got js=%b, expected %b", k, jump_start, (k == 7));
      end
    end
    jump_btn = 1'b0;
    wait_ground(60);
    cyc(6);
  endtask

  task automatic test_bounce();
    clear_rec();
    for (int i = 0; i < 10; i++) begin jump_btn = ~jump_btn; cyc(2); end
    checks++;
    if (js_cnt != 0) begin
      errors++; $display("FAIL bounce_reject got js_cnt=%0d, expected 0", js_cnt);
    end
    jump_btn = 1'b1;
    cyc(10);
    checks++;
    if (js_cnt != 1) begin
      errors++; $display("FAIL bounce_accept got js_cnt=%0d, expected 1", js_cnt);
    end
    jump_btn = 1'b0;
    wait_ground(60);
    cyc(6);
  endtask

  task automatic test_trajectory();
    int exp_h[6] = '{3, 5, 6, 5, 3, 0};
    clear_rec();
    jump_btn = 1'b1; cyc(6); jump_btn = 1'b0;
    wait_ground(60);
    cyc(4);
    checks++;
    if (hq.size() != 6) begin
      errors++; $display("FAIL traj_len got %0d height changes, expected 6", hq.size());
    end else begin
      for (int k = 0; k < 6; k++) begin
        checks++;
        if (hq[k] != exp_h[k]) begin
          errors++; $display("FAIL traj_h[%0d] got %0d, expected %0d", k, hq[k], exp_h[k]);
        end
      end
    end
    checks++;
    if (ld_cnt != 1 || js_cnt != 1 || airborne !== 1'b0) begin
      errors++;
      $display("FAIL traj_pulses got ld=%0d js=%0d air=%b, expected ld=1 js=1 air=0", ld_cnt, js_cnt, airborne);
    end
    cyc(4);
  endtask

  task automatic test_held();
    clear_rec();
    jump_btn = 1'b1; cyc(100);
    checks++;
    if (js_cnt != 1 || ld_cnt != 1) begin
      errors++; $display("FAIL held_single got js=%0d ld=%0d, expected js=1 ld=1", js_cnt, ld_cnt);
    end
    jump_btn = 1'b0; cyc(8);
    jump_btn = 1'b1; cyc(6); jump_btn = 1'b0;
    wait_ground(60);
    checks++;
    if (js_cnt != 2) begin
      errors++; $display("FAIL held_repress got js=%0d, expected 2", js_cnt);
    end
    cyc(6);
  endtask

  task automatic test_airborne_press();
    int inc[3] = '{3, 5, 6};
    int base;
    align_tick(0);
    clear_rec();
    jump_btn = 1'b1; cyc(4);
    jump_btn = 1'b0; cyc(4);
    jump_btn = 1'b1; cyc(4);
    jump_btn = 1'b0; cyc(5);
    jump_btn = 1'b1; cyc(5);
    jump_btn = 1'b0;
    wait_ground(80);
    cyc(4);
    checks++;
    if (js_cnt != 2) begin
      errors++; $display("FAIL air_js_count got %0d, expected 2", js_cnt);
    end
    checks++;
    if (ld_cnt != (DJ ? 1 : 2)) begin
      errors++; $display("FAIL air_ld_count got %0d, expected %0d", ld_cnt, (DJ ? 1 : 2));
    end
    base = DJ ? 5 : 0;
    if (jsq.size() >= 2 && hq.size() >= jsidx[1] + 3) begin
      checks++;
      if (jsq[1] != base) begin
        errors++; $display("FAIL air_launch_h got %0d, expected %0d", jsq[1], base);
      end
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (hq[jsidx[1] + k] != base + inc[k]) begin
          errors++; $display("FAIL air_traj[%0d] got %0d, expected %0d", k, hq[jsidx[1] + k], base + inc[k]);
        end
      end
    end else begin
      checks++; errors++;
      $display("FAIL air_record got %0d launches %0d changes, expected 2 launches", jsq.size(), hq.size());
    end
    cyc(6);
  endtask

  task automatic test_coincide();
    align_tick(1);
    clear_rec();
    jump_btn = 1'b1; cyc(6); jump_btn = 1'b0;
    cyc(1);
    checks++;
    if (jump_start !== 1'b1 || height !== 8'd0 || airborne !== 1'b1) begin
      errors++; $display("FAIL coin_launch got js=%b h=%0d air=%b, expected js=1 h=0 air=1", jump_start, height, airborne);
    end
    cyc(1);
    checks++;
    if (height !== 8'd0) begin
      errors++; $display("FAIL coin_hold got h=%0d, expected 0", height);
    end
    cyc(1);
    checks++;
    if (height !== 8'd3) begin
      errors++; $display("FAIL coin_first_tick got h=%0d, expected 3", height);
    end
    wait_ground(60);
    cyc(6);
  endtask

  task automatic test_abort();
    int n = 0;
    clear_rec();
    jump_btn = 1'b1; cyc(6); jump_btn = 1'b0;
    while (height !== 8'd6 && n < 60) begin cyc(1); n++; end
    checks++;
    if (height !== 8'd6) begin
      errors++; $display("FAIL abort_reach6 got h=%0d, expected 6", height);
    end
    game_run = 1'b0;
    cyc(1);
    checks++;
    if (height !== 8'd0 || airborne !== 1'b0 || landed !== 1'b0) begin
      errors++; $display("FAIL abort_gamerun got h=%0d air=%b ld=%b, expected 0 0 0", height, airborne, landed);
    end
    jump_btn = 1'b1; cyc(6); jump_btn = 1'b0; cyc(4);
    game_run = 1'b1;
    cyc(10);
    checks++;
    if (js_cnt != 1 || ld_cnt != 0) begin
      errors++; $display("FAIL abort_discard got js=%0d ld=%0d, expected js=1 ld=0", js_cnt, ld_cnt);
    end
    // Asynchronous reset in the middle of a jump
    jump_btn = 1'b1; cyc(6); jump_btn = 1'b0;
    n = 0;
    while (height === 8'd0 && n < 40) begin cyc(1); n++; end
    #2 clr = 1'b0;
    #1;
    checks++;
    if ({height, airborne, jump_start, landed} !== 11'd0) begin
      errors++;
      $display("FAIL abort_clr got h=%0d air=%b js=%b ld=%b, expected all 0", height, airborne, jump_start, landed);
    end
    @(posedge clk); #1;
    clr = 1'b1;
    clear_rec();
    cyc(30);
    checks++;
    if (ld_cnt != 0 || js_cnt != 0 || airborne !== 1'b0) begin
      errors++; $display("FAIL abort_after_clr got ld=%0d js=%0d air=%b, expected 0 0 0", ld_cnt, js_cnt, airborne);
    end
  endtask

  task automatic test_random();
    for (int s = 0; s < 80; s++) begin
      jump_btn = 1'($urandom_range(0, 1));
      game_run = ($urandom_range(0, 19) != 0);
      cyc($urandom_range(1, 12));
    end
    game_run = 1'b0; jump_btn = 1'b0;
    cyc(1);
    checks++;
    if (height !== 8'd0 || airborne !== 1'b0) begin
      errors++; $display("FAIL random_end got h=%0d air=%b, expected 0 0", height, airborne);
    end
    game_run = 1'b1;
    cyc(4);
  endtask

  initial begin
    test_reset();
    test_bounce();
    test_trajectory();
    test_held();
    test_airborne_press();
    test_coincide();
    test_abort();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
